bhr_manager: RTL and testbench

//   Owns the 4-bit global branch history feeding the indirect target cache.
//   - Supplies the speculative history (BHR) for fetch-time lookups.
//   - Records the history used by every predicted branch, in program order.
//   - At retire, returns that history as the target cache's update_BHR.
//   - Repairs speculative history on a retire-time mispredict or a pipeline flush.

---
 rtl/bhr_manager.sv | 112 +++++++++++
 tb/tb_bhr_manager.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/bhr_manager.sv
// Speculative / committed global branch history for the indirect target cache.
// Checkpoints the history each predicted branch saw and hands it back in order at retire.
module bhr_manager #(
  parameter int HIST_W     = 4,
  parameter int CKPT_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          br_valid,
  input  logic                          br_taken,
  output logic                          br_ready,
  output logic [HIST_W-1:0]             spec_bhr,
  input  logic                          retire_valid,
  input  logic                          retire_taken,
  input  logic                          retire_mispred,
  input  logic                          flush,
  output logic                          update_valid,
  output logic [HIST_W-1:0]             update_bhr,
  output logic [HIST_W-1:0]             commit_bhr,
  output logic [$clog2(CKPT_DEPTH):0]   ckpt_count,
  output logic                          retire_err
);

  localparam int PTR_W = $clog2(CKPT_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [HIST_W-1:0] ckpt_mem [CKPT_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
  logic [CNT_W-1:0]  count, count_nxt;
  logic [HIST_W-1:0] spec_q, spec_nxt;
  logic [HIST_W-1:0] commit_q, commit_nxt;
  logic              err_q;

  logic              push_req, do_push;
  logic              retire_ok, retire_bad, mispred, squash;
  logic [HIST_W-1:0] head_hist, retired_hist;

  assign push_req     = br_valid & br_ready;
  assign retire_ok    = retire_valid & (count != '0);
  assign retire_bad   = retire_valid & (count == '0);
  assign mispred      = retire_ok & retire_mispred;
  assign squash       = mispred | flush;
  // A push in the same cycle as a repair belongs to the wrong path.
  assign do_push      = push_req & ~squash;

  assign head_hist    = ckpt_mem[rd_ptr];
  assign retired_hist = {head_hist[HIST_W-2:0], retire_taken};

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    rd_ptr_nxt = rd_ptr;
    wr_ptr_nxt = wr_ptr;
    count_nxt  = count;
    spec_nxt   = spec_q;
    commit_nxt = commit_q;

    if (retire_ok) begin
      rd_ptr_nxt = rd_ptr + PTR_W'(1);
      commit_nxt = retired_hist;
    end

    if (squash) begin
      // Mispredict and flush both land on the retire-updated architectural history.
      count_nxt  = '0;
      wr_ptr_nxt = rd_ptr_nxt;
      spec_nxt   = commit_nxt;
    end else begin
      if (do_push) begin
        wr_ptr_nxt = wr_ptr + PTR_W'(1);
        spec_nxt   = {spec_q[HIST_W-2:0], br_taken};
      end
      unique case ({do_push, retire_ok})
        2'b10:   count_nxt = count + CNT_W'(1);
        2'b01:   count_nxt = count - CNT_W'(1);
        default: count_nxt = count;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      spec_q   <= '0;
      commit_q <= '0;
      err_q    <= 1'b0;
    end else begin
      rd_ptr   <= rd_ptr_nxt;
      wr_ptr   <= wr_ptr_nxt;
      count    <= count_nxt;
      spec_q   <= spec_nxt;
      commit_q <= commit_nxt;
      if (retire_bad) err_q <= 1'b1;
    end
  end

  // NOTE: checkpoint storage is not reset; an entry is only read while count says it is valid.
  always_ff @(posedge clk) begin
    if (do_push) ckpt_mem[wr_ptr] <= spec_q;
  end

  assign br_ready     = (count != CNT_W'(CKPT_DEPTH));
  assign spec_bhr     = spec_q;
  assign commit_bhr   = commit_q;
  assign ckpt_count   = count;
  assign retire_err   = err_q;
  assign update_valid = retire_ok;
  assign update_bhr   = retire_ok ? head_hist : '0;

endmodule

// File: tb/tb_bhr_manager.sv
// Self-checking bench for bhr_manager: directed scenarios plus a random run
// against an in-order queue model of the checkpointed branch history.
module tb_bhr_manager;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       br_valid = 1'b0, br_taken = 1'b0;
  logic       retire_valid = 1'b0, retire_taken = 1'b0, retire_mispred = 1'b0, flush = 1'b0;
  logic       br_ready, update_valid, retire_err;
  logic [3:0] spec_bhr, update_bhr, commit_bhr, ckpt_count;

  bhr_manager #(.HIST_W(4), .CKPT_DEPTH(8)) dut (
    .clk(clk), .resetn(resetn),
    .br_valid(br_valid), .br_taken(br_taken), .br_ready(br_ready),
    .spec_bhr(spec_bhr),
    .retire_valid(retire_valid), .retire_taken(retire_taken),
    .retire_mispred(retire_mispred), .flush(flush),
    .update_valid(update_valid), .update_bhr(update_bhr),
    .commit_bhr(commit_bhr), .ckpt_count(ckpt_count), .retire_err(retire_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a queue of histories in program order plus two registers.
  logic [3:0] m_spec, m_commit;
  bit         m_err;
  logic [3:0] m_q[$];
  logic       last_uv;
  logic [3:0] last_ub;

  function automatic void model_reset();
    m_spec = '0; m_commit = '0; m_err = 0; m_q.delete();
  endfunction

  task automatic cycle(input bit bv, input bit bt, input bit rv, input bit rt,
                       input bit mp, input bit fl);
    bit ready, acc, mpa;
    logic [3:0] h;
    @(negedge clk);
    br_valid = bv; br_taken = bt; retire_valid = rv; retire_taken = rt;
    retire_mispred = mp; flush = fl;
    #1;
    ready = (m_q.size() != 8);
    acc   = rv && (m_q.size() != 0);
    mpa   = acc && mp;
    check("br_ready",     br_ready,     ready);
    check("ckpt_count",   ckpt_count,   m_q.size());
    check("spec_bhr",     spec_bhr,     m_spec);
    check("commit_bhr",   commit_bhr,   m_commit);
    check("retire_err",   retire_err,   m_err);
    check("update_valid", update_valid, acc);
    check("update_bhr",   update_bhr,   acc ? m_q[0] : 4'b0);
    last_uv = update_valid;
    last_ub = update_bhr;
    @(posedge clk);
    if (rv && !acc) m_err = 1;
    if (acc) begin
      h = m_q.pop_front();
      m_commit = {h[2:0], rt};
    end
    if (mpa || fl) begin
      m_q.delete();
      m_spec = m_commit;
    end else if (bv && ready) begin
      m_q.push_back(m_spec);
      m_spec = {m_spec[2:0], bt};
    end
  endtask

  task automatic idle_inputs();
    br_valid = 0; br_taken = 0; retire_valid = 0; retire_taken = 0;
    retire_mispred = 0; flush = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    resetn = 0;
    @(negedge clk);
    resetn = 1;
    model_reset();
  endtask

  initial begin
    bit dirs[4];
    logic [3:0] exp_spec[4];
    logic [3:0] exp_ub[4];
    dirs     = '{1'b1, 1'b1, 1'b0, 1'b1};
    exp_spec = '{4'b0001, 4'b0011, 4'b0110, 4'b1101};
    exp_ub   = '{4'b0000, 4'b0001, 4'b0011, 4'b0110};
    model_reset();
    do_reset();

    // T1: asynchronous reset mid-cycle, with a retire request held high.
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    br_valid = 0; retire_valid = 1;
    resetn = 0;
    #1;
    check("t1_spec",     spec_bhr,     4'b0);
    check("t1_commit",   commit_bhr,   4'b0);
    check("t1_count",    ckpt_count,   4'd0);
    check("t1_ready",    br_ready,     1'b1);
    check("t1_uvalid",   update_valid, 1'b0);
    check("t1_ubhr",     update_bhr,   4'b0);
    check("t1_err",      retire_err,   1'b0);
    @(negedge clk);
    idle_inputs();
    resetn = 1;
    model_reset();

    // T2: history shift and in-order retire.
    for (int i = 0; i < 4; i++) begin
      cycle(1, dirs[i], 0, 0, 0, 0);
      #1 check("t2_spec", spec_bhr, exp_spec[i]);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 1, dirs[i], 0, 0);
      check("t2_uvalid", last_uv, 1'b1);
      check("t2_ubhr",   last_ub, exp_ub[i]);
    end
    #1 check("t2_commit", commit_bhr, 4'b1101);

    // T3: full FIFO, refused push, push+retire, pointer wrap.
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1, 1'($urandom % 2), 0, 0, 0, 0);
    #1 check("t3_count8", ckpt_count, 4'd8);
    check("t3_notready", br_ready, 1'b0);
    cycle(1, 1, 0, 0, 0, 0);
    #1 check("t3_9th_ignored", ckpt_count, 4'd8);
    cycle(1, 1, 1, 1'($urandom % 2), 0, 0);
    #1 check("t3_full_pushpop", ckpt_count, 4'd7);
    cycle(1, 0, 1, 1'($urandom % 2), 0, 0);
    #1 check("t3_count7", ckpt_count, 4'd7);
    for (int i = 0; i < 20; i++) begin
      cycle(1, 1'($urandom % 2), 1, 1'($urandom % 2), 0, 0);
      #1 check("t3_wrap_count", ckpt_count, 4'd7);
    end

    // T4: mispredict on the first retire, with a concurrent push dropped.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, dirs[i], 0, 0, 0, 0);
    cycle(1, 1, 1, 1, 1, 0);
    check("t4_ubhr", last_ub, 4'b0000);
    #1 check("t4_spec",   spec_bhr,   4'b0001);
    check("t4_commit", commit_bhr, 4'b0001);
    check("t4_count",  ckpt_count, 4'd0);

    // T5: flush back to committed history, then underflow.
    do_reset();
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 1, 0, 0);
    cycle(0, 0, 1, 1, 0, 0);
    #1 check("t5_commit_pre", commit_bhr, 4'b0011);
    check("t5_spec_pre", spec_bhr, 4'b1110);
    cycle(1, 1, 0, 0, 0, 1);
    #1 check("t5_spec_post", spec_bhr, 4'b0011);
    check("t5_count_post", ckpt_count, 4'd0);
    cycle(0, 0, 1, 0, 0, 0);
    check("t5_uv_empty", last_uv, 1'b0);
    #1 check("t5_err_set", retire_err, 1'b1);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 1, 0, 0);
    #1 check("t5_err_sticky", retire_err, 1'b1);

    // T6: random traffic against the model.
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      bit rv;
      rv = ($urandom_range(0, 99) < 45);
      cycle(($urandom_range(0, 99) < 60), 1'($urandom % 2), rv, 1'($urandom % 2),
            rv && ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 3));
    end

    @(negedge clk);
    idle_inputs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
